// File: rtl/onewire_slave_sync.sv
// onewire_slave_sync
// Clocked 1-wire slave front end. It oversamples the open-drain line and
// classifies each low pulse as a data slot or a bus reset, in standard or
// overdrive timing. It answers a bus reset with a presence pulse and pulls
// the line low during read slots for zero bits. Words are BW bits, LSB first.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   owr_i               line level from the pad (asynchronous)
//   owr_e               pad output enable; the line is pulled low while 1
//   ena                 slave response enable
//   ovd                 overdrive select, latched on each accepted falling edge
//   tx_data/valid/ready word for the master to read (holding register)
//   rx_data/valid       last word written by the master, one-cycle valid pulse
//   rst_det             one-cycle pulse when a bus reset is detected
//   busy                FSM is not in IDLE
//
// state    | meaning
// IDLE     | waiting for a falling edge on the line
// SLOT     | inside a slot, counting up to the sample point S
// WAIT_HI  | bit sampled; waiting for the line to return high
// RST_LO   | bus reset detected; waiting for the master to release the line
// PRES_GAP | gap of S cycles before the presence pulse
// PRES     | driving the presence pulse for 4*S cycles
module onewire_slave_sync #(
  parameter int CDR_N = 30,
  parameter int CDR_O = 4,
  parameter int BW    = 8,
  parameter int CW    = $clog2(8*CDR_N+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          owr_i,
  output logic          owr_e,
  input  logic          ena,
  input  logic          ovd,
  input  logic [BW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [BW-1:0] rx_data,
  output logic          rx_valid,
  output logic          rst_det,
  output logic          busy
);

  typedef enum logic [2:0] {IDLE, SLOT, WAIT_HI, RST_LO, PRES_GAP, PRES} state_t;

  localparam int BCW = (BW > 1) ? $clog2(BW) : 1;
  localparam logic [CW-1:0]  S1_N     = CW'(CDR_N);
  localparam logic [CW-1:0]  S1_O     = CW'(CDR_O);
  localparam logic [CW-1:0]  S4_N     = CW'(4*CDR_N);
  localparam logic [CW-1:0]  S4_O     = CW'(4*CDR_O);
  localparam logic [CW-1:0]  S8_N     = CW'(8*CDR_N);
  localparam logic [CW-1:0]  S8_O     = CW'(8*CDR_O);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(BW-1);

  state_t         state;
  logic           owr_m, owr_s, owr_s_d;
  logic           fall;
  logic           ovd_l;
  logic [CW-1:0]  cnt, cnt_inc, s1, s4, s8;
  logic [BCW-1:0] bit_cnt;
  logic [BW-1:0]  rx_sh, tx_sh, hold_data, tx_word;
  logic           hold_full, tx_loaded, owr_e_q;
  logic           load_now, tx_act;

  assign fall    = owr_s_d & ~owr_s;
  assign s1      = ovd_l ? S1_O : S1_N;
  assign s4      = ovd_l ? S4_O : S4_N;
  assign s8      = ovd_l ? S8_O : S8_N;
  // The slot counter saturates at 8*S so a stuck-low line never wraps it.
  assign cnt_inc = (cnt < s8) ? cnt + CW'(1) : cnt;

  // A word moves from the holding register only on a word boundary. When the
  // load coincides with a falling edge the first bit comes straight from the
  // holding register so it is not lost.
  assign load_now = (state == IDLE) && (bit_cnt == '0) && hold_full;
  assign tx_word  = load_now ? hold_data : tx_sh;
  assign tx_act   = load_now | tx_loaded;

  assign tx_ready = ~hold_full;
  assign busy     = (state != IDLE);
  // Release the line combinationally on reset or disable.
  assign owr_e    = owr_e_q & ena & ~rst;

  // Synchroniser; resets to the idle-high level so reset cannot fake a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      owr_m   <= 1'b1;
      owr_s   <= 1'b1;
      owr_s_d <= 1'b1;
    end else begin
      owr_m   <= owr_i;
      owr_s   <= owr_m;
      owr_s_d <= owr_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ovd_l     <= 1'b0;
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      tx_loaded <= 1'b0;
      hold_data <= '0;
      hold_full <= 1'b0;
      owr_e_q   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rst_det   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rst_det  <= 1'b0;

      if (tx_valid && !hold_full) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end
      if (load_now) begin
        tx_sh     <= hold_data;
        tx_loaded <= 1'b1;
        hold_full <= 1'b0;
      end

      if (!ena) begin
        state   <= IDLE;
        owr_e_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (fall) begin
              state   <= SLOT;
              cnt     <= CW'(1);
              ovd_l   <= ovd;
              owr_e_q <= tx_act & ~tx_word[0];
            end
          end
          SLOT: begin
            cnt <= cnt_inc;
            if (cnt == s1) begin
              state   <= WAIT_HI;
              owr_e_q <= 1'b0;
              tx_sh   <= tx_word >> 1;
              if (bit_cnt == LAST_BIT) begin
                rx_data   <= {owr_s, rx_sh[BW-1:1]};
                rx_valid  <= 1'b1;
                bit_cnt   <= '0;
                tx_loaded <= 1'b0;
              end else begin
                rx_sh   <= {owr_s, rx_sh[BW-1:1]};
                bit_cnt <= bit_cnt + BCW'(1);
              end
            end
          end
          WAIT_HI: begin
            if (owr_s) begin
              state <= IDLE;
            end else if (cnt >= s8) begin
              // Bus reset: drop the partial word and any loaded tx word,
              // but keep a word still waiting in the holding register.
              state     <= RST_LO;
              rst_det   <= 1'b1;
              bit_cnt   <= '0;
              rx_sh     <= '0;
              tx_sh     <= '0;
              tx_loaded <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          RST_LO: begin
            if (owr_s) begin
              state <= PRES_GAP;
              cnt   <= '0;
            end
          end
          PRES_GAP: begin
            if (cnt == s1 - CW'(1)) begin
              state   <= PRES;
              owr_e_q <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          PRES: begin
            if (cnt == s4 - CW'(1)) begin
              state   <= IDLE;
              owr_e_q <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
